// File: rtl/rr_sched_pkg.sv
// rtl/rr_sched_pkg.sv - shared helpers and request type for the round-robin bank scheduler
package rr_sched_pkg;

    localparam int REQ_ADDR_WIDTH  = 16;
    localparam int REQ_VALUE_WIDTH = 8;

    typedef struct packed {
        logic [REQ_ADDR_WIDTH-1:0]  addr;
        logic [REQ_VALUE_WIDTH-1:0] wdata;
        logic                       we;
    } req_t;

    function automatic int kernel_idx(input int bank, input int port, input int nports);
        return bank * nports + port;
    endfunction

    function automatic int row_width(input int addr_width, input int nbanks);
        return addr_width - $clog2(nbanks);
    endfunction

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_port_arbiter.sv
// rtl/rr_port_arbiter.sv - per-bank round-robin search granting up to NPORTS consumers per cycle
module rr_port_arbiter
    import rr_sched_pkg::*;
#(
    parameter int NCONSUMERS = 8,
    parameter int NPORTS     = 2,
    localparam int IDW       = id_width(NCONSUMERS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NCONSUMERS-1:0]       target,
    output logic [NCONSUMERS-1:0]       grant,
    output logic [NPORTS-1:0]           port_valid,
    output logic [NPORTS-1:0][IDW-1:0]  port_id
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] last_id;
    logic [IDW:0]   slot;
    logic [IDW-1:0] idx;
    int             taken;

    // Walk consumers starting at the pointer; ports fill in search order.
    always_comb begin
        grant      = '0;
        port_valid = '0;
        port_id    = '0;
        last_id    = ptr;
        slot       = '0;
        idx        = '0;
        taken      = 0;
        for (int i = 0; i < NCONSUMERS; i++) begin
            slot = {1'b0, ptr} + (IDW+1)'(i);
            if (slot >= (IDW+1)'(NCONSUMERS)) begin
                slot = slot - (IDW+1)'(NCONSUMERS);
            end
            idx = slot[IDW-1:0];
            if (target[idx] && taken < NPORTS) begin
                grant[idx] = 1'b1;
                for (int p = 0; p < NPORTS; p++) begin
                    if (p == taken) begin
                        port_valid[p] = 1'b1;
                        port_id[p]    = idx;
                    end
                end
                last_id = idx;
                taken++;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= (last_id == IDW'(NCONSUMERS - 1)) ? '0 : last_id + IDW'(1);
        end
    end

endmodule

// File: rtl/rr_bank_scheduler.sv
// rtl/rr_bank_scheduler.sv - multi-consumer to banked multi-port PLM scheduler with read response return
module rr_bank_scheduler
    import rr_sched_pkg::*;
#(
    parameter int NCONSUMERS     = 8,
    parameter int NBANKS         = 4,
    parameter int NPORTS         = 2,
    parameter int ADDR_WIDTH     = 16,
    parameter int VALUE_WIDTH    = 8,
    parameter int PLM_RD_LATENCY = 1,
    localparam int NKERNELS      = NBANKS * NPORTS,
    localparam int ROW_WIDTH     = row_width(ADDR_WIDTH, NBANKS)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NCONSUMERS-1:0]                  req_valid,
    input  logic [NCONSUMERS-1:0][ADDR_WIDTH-1:0]  req_addr,
    input  logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] req_wdata,
    input  logic [NCONSUMERS-1:0]                  req_we,
    output logic [NCONSUMERS-1:0]                  req_ready,
    output logic [NKERNELS-1:0]                    plm_en,
    output logic [NKERNELS-1:0]                    plm_we,
    output logic [NKERNELS-1:0][ROW_WIDTH-1:0]     plm_addr,
    output logic [NKERNELS-1:0][VALUE_WIDTH-1:0]   plm_wdata,
    input  logic [NKERNELS-1:0][VALUE_WIDTH-1:0]   plm_rdata,
    output logic [NCONSUMERS-1:0]                  rsp_valid,
    output logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] rsp_data
);

    localparam int BANK_BITS = $clog2(NBANKS);
    localparam int IDW       = id_width(NCONSUMERS);

    logic [NBANKS-1:0][NCONSUMERS-1:0]      bank_target;
    logic [NBANKS-1:0][NCONSUMERS-1:0]      bank_grant;
    logic [NBANKS-1:0][NPORTS-1:0]          port_valid;
    logic [NBANKS-1:0][NPORTS-1:0][IDW-1:0] port_id;

    logic [NKERNELS-1:0]                  k_en;
    logic [NKERNELS-1:0]                  k_we;
    logic [NKERNELS-1:0][ROW_WIDTH-1:0]   k_addr;
    logic [NKERNELS-1:0][VALUE_WIDTH-1:0] k_wdata;
    logic [NKERNELS-1:0][IDW-1:0]         k_id;

    // Stage s is valid in the cycle s after the command appears on the PLM port.
    logic [PLM_RD_LATENCY:0][NKERNELS-1:0]          rd_v;
    logic [PLM_RD_LATENCY:0][NKERNELS-1:0][IDW-1:0] rd_id;

    logic [NCONSUMERS-1:0]                  rsp_hit;
    logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] rsp_mux;

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        // Holding reset low also suppresses grants, so nothing is accepted while in reset.
        for (genvar c = 0; c < NCONSUMERS; c++) begin : g_target
            assign bank_target[b][c] = reset && req_valid[c] &&
                                       (req_addr[c][BANK_BITS-1:0] == BANK_BITS'(b));
        end

        rr_port_arbiter #(
            .NCONSUMERS (NCONSUMERS),
            .NPORTS     (NPORTS)
        ) u_arb (
            .clk        (clk),
            .reset      (reset),
            .target     (bank_target[b]),
            .grant      (bank_grant[b]),
            .port_valid (port_valid[b]),
            .port_id    (port_id[b])
        );

        for (genvar p = 0; p < NPORTS; p++) begin : g_port
            localparam int K = kernel_idx(b, p, NPORTS);
            logic [IDW-1:0] id;
            assign id         = port_id[b][p];
            assign k_en[K]    = port_valid[b][p];
            assign k_we[K]    = port_valid[b][p] & req_we[id];
            assign k_addr[K]  = req_addr[id][ADDR_WIDTH-1:BANK_BITS];
            assign k_wdata[K] = req_wdata[id];
            assign k_id[K]    = id;
        end
    end

    always_comb begin
        req_ready = '0;
        for (int b = 0; b < NBANKS; b++) begin
            req_ready = req_ready | bank_grant[b];
        end
    end

    // A consumer owns at most one kernel per cycle, so the response steering never collides.
    always_comb begin
        rsp_hit = '0;
        rsp_mux = '0;
        for (int k = 0; k < NKERNELS; k++) begin
            if (rd_v[PLM_RD_LATENCY][k]) begin
                rsp_hit[rd_id[PLM_RD_LATENCY][k]] = 1'b1;
                rsp_mux[rd_id[PLM_RD_LATENCY][k]] = plm_rdata[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            plm_en    <= '0;
            plm_we    <= '0;
            plm_addr  <= '0;
            plm_wdata <= '0;
            rd_v      <= '0;
            rd_id     <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            plm_en <= k_en;
            plm_we <= k_we;
            for (int k = 0; k < NKERNELS; k++) begin
                if (k_en[k]) begin
                    plm_addr[k]  <= k_addr[k];
                    plm_wdata[k] <= k_wdata[k];
                end
            end
            rd_v[0]  <= k_en & ~k_we;
            rd_id[0] <= k_id;
            for (int s = 1; s <= PLM_RD_LATENCY; s++) begin
                rd_v[s]  <= rd_v[s-1];
                rd_id[s] <= rd_id[s-1];
            end
            rsp_valid <= rsp_hit;
            for (int c = 0; c < NCONSUMERS; c++) begin
                if (rsp_hit[c]) begin
                    rsp_data[c] <= rsp_mux[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_rr_bank_scheduler.sv
// tb/tb_rr_bank_scheduler.sv - directed and randomized checks of rr_bank_scheduler against a behavioural model
module tb_rr_bank_scheduler;
    import rr_sched_pkg::*;

    localparam int NC  = 8;
    localparam int NB  = 4;
    localparam int NP  = 2;
    localparam int AW  = 16;
    localparam int VW  = 8;
    localparam int LAT = 1;
    localparam int NK  = NB * NP;
    localparam int RW  = AW - 2;

    logic                   clk;
    logic                   reset;
    logic [NC-1:0]          req_valid;
    logic [NC-1:0][AW-1:0]  req_addr;
    logic [NC-1:0][VW-1:0]  req_wdata;
    logic [NC-1:0]          req_we;
    logic [NC-1:0]          req_ready;
    logic [NK-1:0]          plm_en;
    logic [NK-1:0]          plm_we;
    logic [NK-1:0][RW-1:0]  plm_addr;
    logic [NK-1:0][VW-1:0]  plm_wdata;
    logic [NK-1:0][VW-1:0]  plm_rdata;
    logic [NC-1:0]          rsp_valid;
    logic [NC-1:0][VW-1:0]  rsp_data;

    rr_bank_scheduler #(
        .NCONSUMERS     (NC),
        .NBANKS         (NB),
        .NPORTS         (NP),
        .ADDR_WIDTH     (AW),
        .VALUE_WIDTH    (VW),
        .PLM_RD_LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_we    (req_we),
        .req_ready (req_ready),
        .plm_en    (plm_en),
        .plm_we    (plm_we),
        .plm_addr  (plm_addr),
        .plm_wdata (plm_wdata),
        .plm_rdata (plm_rdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    always begin
        clk = 1'b0;
        #5;
        clk = 1'b1;
        #5;
    end

    // PLM model: one storage array per bank, read-before-write within a cycle, one-cycle read latency.
    logic [VW-1:0] plm_mem [int];
    always @(posedge clk) begin
        for (int k = 0; k < NK; k++) begin
            if (plm_en[k] && !plm_we[k]) begin
                plm_rdata[k] <= plm_mem.exists(int'(plm_addr[k]) * NB + k / NP) ?
                                plm_mem[int'(plm_addr[k]) * NB + k / NP] : '0;
            end
        end
        for (int k = 0; k < NK; k++) begin
            if (plm_en[k] && plm_we[k]) begin
                plm_mem[int'(plm_addr[k]) * NB + k / NP] = plm_wdata[k];
            end
        end
    end

    // Reference model state
    int            ptr [NB];
    logic [VW-1:0] ref_mem [int];
    logic [VW-1:0] exp_rsp [int];
    logic [NK-1:0] exp_en;
    logic [NK-1:0] exp_we;
    int            exp_addr [NK];
    int            exp_wdata [NK];
    logic [NC-1:0] grant_now;
    int            cyc;
    int            total;
    int            bad;

    function automatic logic [VW-1:0] mem_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++) ptr[b] = 0;
        exp_rsp.delete();
        exp_en = '0;
        exp_we = '0;
    endtask

    // Called just after a falling edge with inputs already driven; returns one falling edge later.
    task automatic step();
        logic [NC-1:0] g;
        int n, last, c, k, key;
        #1;
        g      = '0;
        exp_en = '0;
        exp_we = '0;
        for (int b = 0; b < NB; b++) begin
            n    = 0;
            last = 0;
            for (int d = 0; d < NC; d++) begin
                c = (ptr[b] + d) % NC;
                if (req_valid[c] && (int'(req_addr[c]) % NB) == b && n < NP) begin
                    k            = b * NP + n;
                    g[c]         = 1'b1;
                    exp_en[k]    = 1'b1;
                    exp_we[k]    = req_we[c];
                    exp_addr[k]  = int'(req_addr[c]) / NB;
                    exp_wdata[k] = int'(req_wdata[c]);
                    if (!req_we[c]) exp_rsp[(cyc + 2 + LAT) * NC + c] = mem_rd(int'(req_addr[c]));
                    n++;
                    last = c;
                end
            end
            if (n > 0) ptr[b] = (last + 1) % NC;
        end
        for (int i = 0; i < NC; i++) begin
            if (g[i] && req_we[i]) ref_mem[int'(req_addr[i])] = req_wdata[i];
        end
        grant_now = g;
        chk($sformatf("req_ready@%0d", cyc), 32'(req_ready), 32'(g));
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NK; i++) begin
            chk($sformatf("plm_en[%0d]@%0d", i, cyc), 32'(plm_en[i]), 32'(exp_en[i]));
            chk($sformatf("plm_we[%0d]@%0d", i, cyc), 32'(plm_we[i]), 32'(exp_we[i]));
            if (exp_en[i]) begin
                chk($sformatf("plm_addr[%0d]@%0d", i, cyc), 32'(plm_addr[i]), exp_addr[i]);
                chk($sformatf("plm_wdata[%0d]@%0d", i, cyc), 32'(plm_wdata[i]), exp_wdata[i]);
            end
        end
        for (int i = 0; i < NC; i++) begin
            key = cyc * NC + i;
            if (exp_rsp.exists(key)) begin
                chk($sformatf("rsp_valid[%0d]@%0d", i, cyc), 32'(rsp_valid[i]), 32'd1);
                chk($sformatf("rsp_data[%0d]@%0d", i, cyc), 32'(rsp_data[i]), 32'(exp_rsp[key]));
                exp_rsp.delete(key);
            end else begin
                chk($sformatf("rsp_valid[%0d]@%0d", i, cyc), 32'(rsp_valid[i]), 32'd0);
            end
        end
    endtask

    initial begin
        logic [2:0] t34_exp [3];
        int r, bnk;
        total = 0;
        bad   = 0;
        cyc   = 0;
        model_reset();
        reset     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_we    = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_plm_en", 32'(plm_en), 32'd0);
        chk("rst_plm_we", 32'(plm_we), 32'd0);
        chk("rst_plm_addr", 32'(plm_addr[3]), 32'd0);
        chk("rst_plm_wdata", 32'(plm_wdata[5]), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data[1]), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Consumer 0 writes 25 to address 2
        req_valid[0] = 1'b1; req_addr[0] = 16'd2; req_wdata[0] = 8'd25; req_we[0] = 1'b1;
        #1;
        chk("t32_ready", 32'(req_ready[0]), 32'd1);
        step();
        chk("t32_kernel4", {plm_en[4], plm_we[4], 2'b00, plm_addr[4], plm_wdata[4]},
            {1'b1, 1'b1, 2'b00, 14'd0, 8'd25});
        req_valid = '0;

        // Consumer 0 reads it back; response three cycles after acceptance
        req_valid[0] = 1'b1; req_addr[0] = 16'd2; req_we[0] = 1'b0;
        #1;
        chk("t33_ready", 32'(req_ready[0]), 32'd1);
        step();
        req_valid = '0;
        step();
        chk("t33_early", 32'(rsp_valid), 32'd0);
        step();
        chk("t33_rsp_valid", 32'(rsp_valid), 32'h01);
        chk("t33_rsp_data", 32'(rsp_data[0]), 32'd25);

        // Three consumers hammer bank 1
        t34_exp[0] = 3'b011; t34_exp[1] = 3'b101; t34_exp[2] = 3'b110;
        for (int c = 0; c < 3; c++) begin
            req_valid[c] = 1'b1; req_we[c] = 1'b0; req_addr[c] = AW'(c * 4 * NB + 1);
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t34_grant%0d", i), 32'(req_ready[2:0]), 32'(t34_exp[i]));
            step();
        end
        req_valid = '0;
        repeat (3) step();

        // Eight consumers, two per bank, all granted together
        for (int c = 0; c < NC; c++) begin
            req_valid[c] = 1'b1; req_we[c] = 1'b1;
            req_addr[c]  = AW'((20 + c) * NB + c / 2);
            req_wdata[c] = VW'(100 + c);
        end
        #1;
        chk("t35_ready", 32'(req_ready), 32'hFF);
        step();
        chk("t35_plm_en", 32'(plm_en), 32'hFF);
        req_valid = '0;
        step();

        // Randomized traffic, requests held until accepted
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NC; c++) begin
                if (!req_valid[c] && $urandom_range(0, 2) == 0) begin
                    r   = $urandom_range(0, 3);
                    bnk = $urandom_range(0, NB - 1);
                    req_valid[c] = 1'b1;
                    req_we[c]    = 1'($urandom_range(0, 1));
                    req_addr[c]  = AW'((c * 4 + r) * NB + bnk);
                    req_wdata[c] = VW'($urandom);
                end
            end
            step();
            for (int c = 0; c < NC; c++) begin
                if (grant_now[c]) req_valid[c] = 1'b0;
            end
        end
        req_valid = '0;
        repeat (4) step();

        // Reset with four reads in flight
        for (int c = 0; c < 4; c++) begin
            req_valid[c] = 1'b1; req_we[c] = 1'b0;
            req_addr[c]  = AW'((c + 1) * NB + (c + 1) % NB);
        end
        step();
        req_valid = '0;
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("t36_plm_en", 32'(plm_en), 32'd0);
        chk("t36_plm_we", 32'(plm_we), 32'd0);
        chk("t36_plm_addr", 32'(plm_addr[0]), 32'd0);
        chk("t36_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t36_rsp_data", 32'(rsp_data[3]), 32'd0);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cyc++;
            chk($sformatf("t36_in_reset_rsp%0d", i), 32'(rsp_valid), 32'd0);
        end
        reset = 1'b1;
        repeat (4) step();
        req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = AW'(8 * NB);
        req_valid[5] = 1'b1; req_we[5] = 1'b0; req_addr[5] = AW'(20 * NB);
        req_valid[6] = 1'b1; req_we[6] = 1'b0; req_addr[6] = AW'(24 * NB);
        #1;
        chk("t36_first_grant", 32'(req_ready), 32'h24);
        step();
        req_valid = '0;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
